booth_mul_seq: RTL and testbench

Sequential radix-4 Booth multiplier, parametrised in operand width, for the CPU datapath's MUL/MULU path. It retires one Booth digit per clock, supports signed and unsigned operands, and uses a start/busy/done handshake. It writes a 2×WIDTH-bit product to the HI/LO register inputs. It replaces the single-shot combinational multiplier, so the multiply no longer sits in one long combinational path.

---
 rtl/booth_mul_seq.sv | 142 ++++++++++++++
 tb/tb_booth_mul_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed or unsigned
// operands, start/busy/done handshake, 2*WIDTH-bit product on registered HI/LO.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int PW = E + 2;
  localparam int SW = PW + E + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [E-1:0]    m_q, m_d;
  logic [PW-1:0]   p_q, p_d;
  logic [E-1:0]    q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [PW-1:0]   m_ext_s;
  logic [PW-1:0]   addend_s;
  logic [PW-1:0]   p_sum_s;
  logic [SW-1:0]   shr_s;
  logic [2:0]      triplet_s;
  logic [E-1:0]    a_ext_s;
  logic [E-1:0]    b_ext_s;

  // Booth digit decode, add into P, then arithmetic shift of {P,Q,q-1} by two.
  always_comb begin
    triplet_s = {q_q[1:0], qm1_q};
    m_ext_s   = {{2{m_q[E-1]}}, m_q};
    case (triplet_s)
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = {m_ext_s[PW-2:0], 1'b0};
      3'b100:         addend_s = ~{m_ext_s[PW-2:0], 1'b0} + {{(PW-1){1'b0}}, 1'b1};
      3'b101, 3'b110: addend_s = ~m_ext_s + {{(PW-1){1'b0}}, 1'b1};
      default:        addend_s = {PW{1'b0}};
    endcase
    p_sum_s = p_q + addend_s;
    shr_s   = {{2{p_sum_s[PW-1]}}, p_sum_s, q_q[E-1:1]};
    // Extension by two bits keeps unsigned operands positive inside the Booth recoding.
    a_ext_s = signed_op ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    b_ext_s = signed_op ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a_ext_s;
          p_d     = {PW{1'b0}};
          q_d     = b_ext_s;
          qm1_d   = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = shr_s[SW-1:E+1];
        q_d   = shr_s[E:1];
        qm1_d = shr_s[0];
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(N - 1)) begin
          // Product bit j sits at shr_s[j+1]; q-1 occupies bit 0.
          hi_d    = shr_s[2*WIDTH:WIDTH+1];
          lo_d    = shr_s[WIDTH:1];
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      m_q     <= {E{1'b0}};
      p_q     <= {PW{1'b0}};
      q_q     <= {E{1'b0}};
      qm1_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq at WIDTH=32 and WIDTH=8 against an integer reference product.
module tb_booth_mul_seq;

  localparam int N32 = 17;
  localparam int N8  = 5;

  logic        clk = 1'b0;
  logic        clr;
  logic        st32, s32, st8, s8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  booth_mul_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .clr(clr), .start(st32), .signed_op(s32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .HI(hi32), .LO(lo32)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .start(st8), .signed_op(s8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: interpret each w-bit operand as signed or unsigned, multiply as 64-bit integers.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) <<< w);
    if (s && b[w-1]) vb = vb - (longint'(1) <<< w);
    return 64'(va * vb);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold);
    exp_t e;
    @(negedge clk);
    a32 = a; b32 = b; s32 = s; st32 = 1'b1;
    e.prod = ref_mul(a, b, s, 32);
    e.due  = cyc + 1 + N32;
    q32.push_back(e);
    for (int i = 1; i <= N32; i++) begin
      @(negedge clk);
      a32  = $urandom;
      b32  = $urandom;
      s32  = 1'($urandom);
      st32 = hold ? 1'b1 : (i == 3);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit hold);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; st8 = 1'b1;
    e.prod = ref_mul({24'd0, a}, {24'd0, b}, s, 8);
    e.due  = cyc + 1 + N8;
    q8.push_back(e);
    for (int i = 1; i <= N8; i++) begin
      @(negedge clk);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      s8  = 1'($urandom);
      st8 = hold ? 1'b1 : (i == 3);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    st32 = 1'b0;
    st8  = 1'b0;
    for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q32.size() != 0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: pending32=%0d pending8=%0d expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  initial begin
    clr = 1'b1;
    st32 = 1'b0; s32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    st8  = 1'b0; s8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
    fork
      // Monitor: pops the scoreboard whenever a DUT presents done.
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!clr) begin
            if (busy32 && done32) begin
              n_err++;
              $display("FAIL busy_done32: both high at cycle %0d", cyc);
            end
            if (busy8 && done8) begin
              n_err++;
              $display("FAIL busy_done8: both high at cycle %0d", cyc);
            end
            if (done32) begin
              if (q32.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done32: done at cycle %0d with nothing pending", cyc);
              end else begin
                e = q32.pop_front();
                chk("product32", {hi32, lo32}, e.prod);
                chk("latency32", 64'(cyc), 64'(e.due));
              end
            end
            if (done8) begin
              if (q8.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done8: done at cycle %0d with nothing pending", cyc);
              end else begin
                e = q8.pop_front();
                chk("product8", {48'd0, hi8, lo8}, {48'd0, e.prod[15:0]});
                chk("latency8", 64'(cyc), 64'(e.due));
              end
            end
          end
        end
      end
      // Stimulus.
      begin
        repeat (3) @(negedge clk);
        chk("rst_busy32", {63'd0, busy32}, 64'd0);
        chk("rst_done32", {63'd0, done32}, 64'd0);
        chk("rst_hilo32", {hi32, lo32}, 64'd0);
        chk("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        clr = 1'b0;

        run32(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b0);
        drain();
        chk("signed_basic", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFEB);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();
        chk("most_neg_unsigned", {hi32, lo32}, 64'h4000_0000_0000_0000);

        // Abort mid-RUN: nothing pushed, so any later done is flagged by the monitor.
        @(negedge clk);
        a32 = 32'd5; b32 = 32'd7; s32 = 1'b0; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy32}, 64'd0);
        chk("abort_done", {63'd0, done32}, 64'd0);
        chk("abort_hilo", {hi32, lo32}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", {63'd0, busy32}, 64'd0);
        chk("abort_idle_hilo", {hi32, lo32}, 64'd0);

        for (int i = 0; i < 6; i++) begin
          run32((i % 2 == 0) ? 32'h1234_5678 : $urandom,
                (i % 2 == 0) ? 32'h8765_4321 : $urandom, 1'(i % 3 == 0), 1'b1);
        end
        drain();
        for (int i = 0; i < 20; i++) run32($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();

        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < 2000; i++) run8(8'($urandom), 8'($urandom), 1'(m), 1'($urandom));
          drain();
        end
      end
      // Watchdog.
      begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
